// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding, default widths and retire-counter constants for pc_seq.
package pc_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
    localparam int PC_W_DEF  = 10;
    localparam int PTR_W_DEF = 5;
    localparam int OFF_W_DEF = 8;
    localparam int CNT_W     = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return x == CNT_MAX ? x : x + 1'b1;
    endfunction
endpackage

// File: rtl/pc_offset_tbl.sv
// pc_offset_tbl: branch-offset register file, synchronous write and clear, combinational signed read.
module pc_offset_tbl #(
    parameter int PTR_W = 5,
    parameter int OFF_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [PTR_W-1:0]        waddr,
    input  logic [OFF_W-1:0]        wdata,
    input  logic [PTR_W-1:0]        raddr,
    output logic signed [OFF_W-1:0] rdata
);
    logic [OFF_W-1:0] mem [2**PTR_W];
    assign rdata = $signed(mem[raddr]);
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**PTR_W; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/pc_seq.sv
// pc_seq: PC register, hold/increment/table-relative branch/halt sequencing and retire counter.
// Define PC_SEQ_BOUND_CHK_EN to halt on out-of-range PC results instead of wrapping.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int PTR_W = PTR_W_DEF,
    parameter int OFF_W = OFF_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             stall,
    input  logic             branch,
    input  logic [PTR_W-1:0] jump_ptr,
    input  logic             halt_req,
    input  logic             tbl_we,
    input  logic [PTR_W-1:0] tbl_waddr,
    input  logic [OFF_W-1:0] tbl_wdata,
    output logic [PC_W-1:0]  pc,
    output logic             pc_valid,
    output logic             done,
    output logic             tbl_err,
    output logic [CNT_W-1:0] instr_cnt
);
`ifdef PC_SEQ_BOUND_CHK_EN
    localparam bit BOUND_CHK = 1'b1;
`else
    localparam bit BOUND_CHK = 1'b0;
`endif
    state_t state;
    logic signed [OFF_W-1:0] off;
    logic [PC_W+1:0] step, sum;
    logic run, fault;
    assign run = state == RUN;
    pc_offset_tbl #(.PTR_W(PTR_W), .OFF_W(OFF_W)) u_tbl (
        .clk(clk), .reset(reset), .we(tbl_we && !run), .waddr(tbl_waddr),
        .wdata(tbl_wdata), .raddr(jump_ptr), .rdata(off)
    );
    // Two guard bits: MSB flags a negative result, the next flags overflow past the top.
    assign step  = branch ? {{(PC_W+2-OFF_W){off[OFF_W-1]}}, off} : (PC_W+2)'(1);
    assign sum   = {2'b00, pc} + step;
    assign fault = BOUND_CHK && (sum[PC_W+1] || sum[PC_W]);
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            pc_valid  <= 1'b0;
            done      <= 1'b0;
            tbl_err   <= 1'b0;
            instr_cnt <= '0;
        end else begin
            tbl_err <= tbl_we && run;
            if (!run) begin
                if (start) begin
                    state     <= RUN;
                    pc        <= start_addr;
                    pc_valid  <= 1'b1;
                    done      <= 1'b0;
                    instr_cnt <= '0;
                end
            end else if (!stall) begin
                if (halt_req || fault) begin
                    state    <= HALTED;
                    pc_valid <= 1'b0;
                    done     <= 1'b1;
                    if (halt_req) instr_cnt <= sat_inc(instr_cnt);
                    else tbl_err <= 1'b1;
                end else begin
                    pc        <= sum[PC_W-1:0];
                    instr_cnt <= sat_inc(instr_cnt);
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed test-plan sequence plus randomized traffic against a behavioural model of pc_seq.
module tb_pc_seq;
`ifdef PC_SEQ_BOUND_CHK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset, start, stall, branch, halt_req, tbl_we;
    logic [9:0] start_addr, pc;
    logic [4:0] jump_ptr, tbl_waddr;
    logic [7:0] tbl_wdata;
    logic pc_valid, done, tbl_err;
    logic [15:0] instr_cnt;
    int n_pass = 0, n_tot = 0;
    // Model: run_st 0=idle 1=run 2=halted, PC as plain integer.
    int m_st, m_pc, m_cnt, m_err;
    int m_tbl [32];
    bit armed = 1'b0;

    pc_seq dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .stall(stall),
        .branch(branch), .jump_ptr(jump_ptr), .halt_req(halt_req), .tbl_we(tbl_we),
        .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata), .pc(pc), .pc_valid(pc_valid),
        .done(done), .tbl_err(tbl_err), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_st = 0; m_pc = 0; m_cnt = 0; m_err = 0;
            foreach (m_tbl[i]) m_tbl[i] = 0;
            armed = 1'b1;
        end else begin
            int e, nxt;
            e = 0;
            if (m_st != 1) begin
                if (tbl_we) m_tbl[tbl_waddr] = int'($signed(tbl_wdata));
                if (start) begin m_st = 1; m_pc = int'(start_addr); m_cnt = 0; end
            end else begin
                if (tbl_we) e = 1;
                if (!stall) begin
                    if (halt_req) begin
                        m_st = 2;
                        if (m_cnt < 65535) m_cnt++;
                    end else begin
                        nxt = m_pc + (branch ? m_tbl[jump_ptr] : 1);
                        if (BOUND && (nxt < 0 || nxt > 1023)) begin
                            m_st = 2; e = 1;
                        end else begin
                            m_pc = ((nxt % 1024) + 1024) % 1024;
                            if (m_cnt < 65535) m_cnt++;
                        end
                    end
                end
            end
            m_err = e;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("pc", int'(pc), m_pc);
            chk("pc_valid", int'(pc_valid), int'(m_st == 1));
            chk("done", int'(done), int'(m_st == 2));
            chk("tbl_err", int'(tbl_err), m_err);
            chk("instr_cnt", int'(instr_cnt), m_cnt);
        end
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_in();
        reset = 0; start = 0; stall = 0; branch = 0; halt_req = 0; tbl_we = 0;
        start_addr = '0; jump_ptr = '0; tbl_waddr = '0; tbl_wdata = '0;
    endtask

    task automatic wr(input int a, input int d);
        tbl_we = 1; tbl_waddr = 5'(a); tbl_wdata = 8'(d);
        step();
        tbl_we = 0;
    endtask

    task automatic go(input int a);
        start = 1; start_addr = 10'(a);
        step();
        start = 0;
    endtask

    initial begin
        idle_in();
        reset = 1;
        step(2);
        reset = 0;
        chk("rst_pc", int'(pc), 0);
        chk("rst_done", int'(done), 0);
        wr(0, 0); wr(1, -11); wr(2, 7);
        go(20);
        chk("start_pc", int'(pc), 20);
        chk("start_valid", int'(pc_valid), 1);
        step(10);
        chk("inc_pc", int'(pc), 30);
        chk("inc_cnt", int'(instr_cnt), 10);
        branch = 1; jump_ptr = 1; step();
        chk("br_neg_pc", int'(pc), 19);
        jump_ptr = 2; step();
        chk("br_pos_pc", int'(pc), 26);
        chk("br_cnt", int'(instr_cnt), 12);
        branch = 0; step(14);
        stall = 1; branch = 1; jump_ptr = 2; step(3);
        chk("stall_pc", int'(pc), 40);
        chk("stall_cnt", int'(instr_cnt), 26);
        stall = 0; step();
        chk("unstall_br", int'(pc), 47);
        branch = 0; step(3);
        halt_req = 1; step(); halt_req = 0;
        chk("halt_pc", int'(pc), 50);
        chk("halt_done", int'(done), 1);
        chk("halt_valid", int'(pc_valid), 0);
        chk("halt_cnt", int'(instr_cnt), 31);
        go(0);
        chk("restart_cnt", int'(instr_cnt), 0);
        wr(1, 5);
        chk("rej_err", int'(tbl_err), 1);
        step();
        chk("rej_err_clr", int'(tbl_err), 0);
        branch = 1; jump_ptr = 1; step(); branch = 0;
        chk("wrap_neg_pc", int'(pc), BOUND ? 2 : 1015);
        halt_req = 1; step(); halt_req = 0;
        go(1023);
        step();
        chk("wrap_top_pc", int'(pc), BOUND ? 1023 : 0);
        chk("wrap_top_done", int'(done), BOUND ? 1 : 0);
        chk("wrap_top_err", int'(tbl_err), BOUND ? 1 : 0);
        halt_req = 1; step(); halt_req = 0;
        go(77);
        chk("mid_pc", int'(pc), 77);
        reset = 1; step(); reset = 0;
        chk("mid_rst_pc", int'(pc), 0);
        chk("mid_rst_cnt", int'(instr_cnt), 0);
        chk("mid_rst_valid", int'(pc_valid), 0);
        go(100);
        branch = 1; jump_ptr = 1; step(); branch = 0;
        chk("tbl_cleared", int'(pc), 100);
        for (int c = 0; c < 4000; c++) begin
            reset      = ($urandom_range(0, 199) == 0);
            start      = ($urandom_range(0, 19) == 0);
            start_addr = 10'($urandom_range(0, 1023));
            stall      = ($urandom_range(0, 4) == 0);
            branch     = ($urandom_range(0, 2) == 0);
            jump_ptr   = 5'($urandom_range(0, 31));
            halt_req   = ($urandom_range(0, 39) == 0);
            tbl_we     = ($urandom_range(0, 6) == 0);
            tbl_waddr  = 5'($urandom_range(0, 31));
            tbl_wdata  = 8'($urandom);
            step();
        end
        idle_in();
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/pc_seq.md
# pc_seq

Program counter sequencer for the single-cycle core. It owns the PC register and a writable 32-entry signed branch-offset table, and decides each cycle among hold, increment, relative branch through the table, and halt. It sits between the decoder's control outputs and the instruction ROM address port. It also counts retired instructions for the testbench's performance report.

## Interface
Parameters:
- PC_W, 10, PC / instruction-address width
- PTR_W, 5, offset-table index width (2^PTR_W entries)
- OFF_W, 8, signed offset width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin execution; honoured in IDLE or HALTED only
- start_addr  in  PC_W  first PC after start
- stall  in  1  hold current PC; instruction not retired
- branch  in  1  taken relative branch for the current instruction
- jump_ptr  in  PTR_W  offset-table index used when branch=1
- halt_req  in  1  current instruction is halt
- tbl_we  in  1  offset-table write enable
- tbl_waddr  in  PTR_W  table write index
- tbl_wdata  in  OFF_W  signed offset to store
- pc  out  PC_W  current instruction address (registered)
- pc_valid  out  1  pc addresses a live instruction (state RUN)
- done  out  1  state HALTED
- tbl_err  out  1  one-cycle pulse: table write rejected
- instr_cnt  out  16  retired instructions since last start

## Operation
- States: IDLE, RUN, HALTED. Reset → IDLE; pc=0, pc_valid=0, done=0, tbl_err=0, instr_cnt=0, all table entries=0.
- IDLE/HALTED: start=1 → RUN, pc=start_addr, instr_cnt=0, done=0. Other control inputs are ignored.
- RUN priority, highest first: stall → pc held, no retire; halt_req → HALTED, pc held, retire; branch → pc = pc + sext(tbl[jump_ptr]), retire; else pc = pc + 1, retire.
- Arithmetic: offset sign-extended to PC_W; sum taken modulo 2^PC_W (wrap), unless the macro below is defined.
- Offset 0 is a legal branch-to-self (tight loop).
- Retire increments instr_cnt, saturating at 16'hFFFF.
- Table writes: accepted in IDLE and HALTED and committed at the edge. A write while in RUN is dropped, and tbl_err pulses for one cycle.
- Table read is combinational. Write and branch to the same index in the same cycle are impossible, because writes are rejected in RUN.
- start and tbl_we in the same IDLE cycle: both take effect.
- reset in any state, mid-run included, wins over everything, including the table contents.

## Timing
- pc is registered. Its new value is visible the cycle after the deciding inputs. Branch resolution has zero bubbles.
- start sampled at edge N → pc=start_addr and pc_valid=1 from N+1.
- halt_req at edge N → done=1 and pc_valid=0 from N+1. pc keeps the halt address.
- tbl_err is asserted in the cycle after the rejected write and cleared the next cycle.

## Configuration
- PC_SEQ_BOUND_CHK_EN defined: a branch or increment whose unwrapped result leaves [0, 2^PC_W−1] instead goes to HALTED. pc is held, done=1, and tbl_err pulses as a fault indicator. instr_cnt is not incremented.
- Undefined: silent modulo wrap, as described above.

## Structure
- Package pc_seq_pkg holds:
  - the state enum (IDLE, RUN, HALTED)
  - default widths PC_W/PTR_W/OFF_W
  - the instr_cnt width and saturation constant
- Sub-module pc_offset_tbl: 2^PTR_W × OFF_W register file with synchronous write, combinational signed read, and synchronous clear on reset. pc_seq instantiates it once.

## Test plan
- Reset, then tbl writes {0:+0, 1:−11, 2:+7}, then start with start_addr=20 → pc sequence 20,21,22…; pc_valid=1 from the cycle after start.
- In RUN at pc=30, branch=1, jump_ptr=1 → next pc=19. At pc=19, branch, ptr 2 → pc=26. instr_cnt increments each step.
- stall held 3 cycles at pc=40, with branch asserted → pc stays 40 and instr_cnt is unchanged. On release, the branch takes effect.
- halt_req at pc=50 → done=1 and pc_valid=0 next cycle, pc=50. start again with start_addr=0 → RUN, instr_cnt=0.
- tbl_we during RUN → entry unchanged and tbl_err one-cycle pulse. Wrap check: pc=1023, increment → pc=0 with the macro undefined. With PC_SEQ_BOUND_CHK_EN defined → HALTED, pc=1023.
- reset asserted mid-run at pc=77 → next cycle IDLE, pc=0, instr_cnt=0, table entry 1 reads 0.
